// File: rtl/inst_rom_pkg.sv
// Shared types and constants for the instruction ROM and its byte-serial boot loader.
package inst_rom_pkg;

   typedef logic [31:0] inst_bus_t;
   typedef logic [31:0] inst_addr_bus_t;

   localparam inst_bus_t ZERO_WORD    = 32'h0000_0000;
   localparam inst_bus_t NOP_INST     = 32'h0000_0000;
   localparam logic      CHIP_ENABLE  = 1'b1;
   localparam logic      CHIP_DISABLE = 1'b0;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   // Byte lane that the cnt-th received byte of a word lands in.
   function automatic logic [1:0] byte_lane(input logic [1:0] cnt, input logic big_end);
      return big_end ? ~cnt : cnt;
   endfunction

endpackage

// File: rtl/inst_rom.sv
// Instruction memory for the CPU fetch port, filled by a byte-serial boot loader.
// Fetch is combinational (zero latency); loader writes one word per 4 bytes, flush on load_end.
// No backpressure on the loader; fetch returns NOP and stallreq_o is high while loading.
module inst_rom
   import inst_rom_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter bit BIG_END = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce,
   input  logic [31:0]       addr,
   output logic [31:0]       inst,
   input  logic              load_start,
   input  logic              load_valid,
   input  logic [7:0]        load_byte,
   input  logic              load_end,
   output logic              busy,
   output logic              stallreq_o,
   output logic [ADDR_W:0]   words_loaded,
   output logic              overflow
);

   localparam int              DEPTH   = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_V = {1'b1, {ADDR_W{1'b0}}};

   logic [31:0]       mem [DEPTH];
   logic [1:0]        state;
   logic [1:0]        byte_cnt;
   logic [ADDR_W:0]   wr_ptr;
   logic [31:0]       asm_word;
   logic [31:0]       merged;
   logic [31:0]       word_dat;
   logic              word_due;
   logic              mem_we;
   logic [ADDR_W-1:0] rd_idx;
   logic              unused_addr_lsb;

   assign unused_addr_lsb = &{1'b0, addr[1:0]};

   always_comb begin
      merged = asm_word;
      merged[{byte_lane(byte_cnt, BIG_END), 3'b000} +: 8] = load_byte;
   end

   // A restart in LOAD takes priority over any byte arriving in the same cycle.
   always_comb begin
      word_due = 1'b0;
      word_dat = merged;
      if (state == ST_LOAD && !load_start && load_valid && byte_cnt == 2'd3) begin
         word_due = 1'b1;
      end else if (state == ST_FLUSH && byte_cnt != 2'd0) begin
         word_due = 1'b1;
         word_dat = asm_word;
      end
   end

   assign mem_we = word_due && (wr_ptr != DEPTH_V);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         byte_cnt     <= 2'd0;
         wr_ptr       <= '0;
         asm_word     <= ZERO_WORD;
         words_loaded <= '0;
         overflow     <= 1'b0;
         busy         <= 1'b0;
      end else begin
         busy <= (state != ST_IDLE);
         case (state)
            ST_IDLE: begin
               if (load_start) begin
                  state        <= ST_LOAD;
                  byte_cnt     <= 2'd0;
                  wr_ptr       <= '0;
                  asm_word     <= ZERO_WORD;
                  words_loaded <= '0;
                  overflow     <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (load_start) begin
                  byte_cnt     <= 2'd0;
                  wr_ptr       <= '0;
                  asm_word     <= ZERO_WORD;
                  words_loaded <= '0;
                  overflow     <= 1'b0;
               end else begin
                  if (load_valid) begin
                     byte_cnt <= byte_cnt + 2'd1;
                     asm_word <= (byte_cnt == 2'd3) ? ZERO_WORD : merged;
                  end
                  if (load_end) begin
                     state <= ST_FLUSH;
                  end
               end
            end
            ST_FLUSH: begin
               state    <= ST_IDLE;
               byte_cnt <= 2'd0;
               asm_word <= ZERO_WORD;
            end
            default: state <= ST_IDLE;
         endcase

         // Writes past the end are dropped; the loader keeps consuming until load_end.
         if (word_due) begin
            if (wr_ptr == DEPTH_V) begin
               overflow <= 1'b1;
            end else begin
               wr_ptr <= wr_ptr + 1'b1;
               if (words_loaded != DEPTH_V) begin
                  words_loaded <= words_loaded + 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[wr_ptr[ADDR_W-1:0]] <= word_dat;
      end
   end

   assign stallreq_o = busy;
   assign rd_idx     = addr[ADDR_W+1:2];

   always_comb begin
      inst = NOP_INST;
      if (ce == CHIP_ENABLE && !busy && !rst && addr[31:ADDR_W+2] == '0) begin
         inst = mem[rd_idx];
      end
   end

endmodule

// File: tb/tb_inst_rom.sv
// Directed bench for inst_rom: a default-depth instance and a 4-word instance for overflow.
module tb_inst_rom;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, ce, load_start, load_valid, load_end, tgt;
   logic [31:0] addr;
   logic [7:0]  load_byte;

   logic        start_b, valid_b, end_b, start_s, valid_s, end_s;
   logic [31:0] inst_b, inst_s;
   logic        busy_b, stall_b, ovf_b, busy_s, stall_s, ovf_s;
   logic [10:0] words_b;
   logic [2:0]  words_s;

   int n_tests = 0;
   int n_fail  = 0;

   assign start_b = load_start & ~tgt;
   assign valid_b = load_valid & ~tgt;
   assign end_b   = load_end   & ~tgt;
   assign start_s = load_start &  tgt;
   assign valid_s = load_valid &  tgt;
   assign end_s   = load_end   &  tgt;

   inst_rom u_dut (
      .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst_b),
      .load_start(start_b), .load_valid(valid_b), .load_byte(load_byte), .load_end(end_b),
      .busy(busy_b), .stallreq_o(stall_b), .words_loaded(words_b), .overflow(ovf_b)
   );

   inst_rom #(.ADDR_W(2)) u_small (
      .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst_s),
      .load_start(start_s), .load_valid(valid_s), .load_byte(load_byte), .load_end(end_s),
      .busy(busy_s), .stallreq_o(stall_s), .words_loaded(words_s), .overflow(ovf_s)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last);
      load_valid = 1'b1;
      load_byte  = b;
      load_end   = last;
      tick();
      load_valid = 1'b0;
      load_end   = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], 1'b0);
   endtask

   task automatic end_load();
      load_end = 1'b1;
      tick();
      load_end = 1'b0;
   endtask

   task automatic fetch(input logic [31:0] a, output logic [31:0] db, output logic [31:0] ds);
      ce   = 1'b1;
      addr = a;
      #1;
      db = inst_b;
      ds = inst_s;
   endtask

   logic [31:0] rb, rs;

   initial begin
      rst = 1'b1; ce = 1'b0; addr = 32'h10; tgt = 1'b0;
      load_start = 1'b0; load_valid = 1'b0; load_end = 1'b0; load_byte = 8'h00;
      tick(); tick();

      // Reset state
      check_eq("rst_inst_ce0", inst_b, 32'h0);
      check_eq("rst_busy", {31'b0, busy_b}, 32'h0);
      check_eq("rst_words", {21'b0, words_b}, 32'h0);
      check_eq("rst_overflow", {31'b0, ovf_b}, 32'h0);
      ce = 1'b1; #1;
      check_eq("rst_inst_ce1", inst_b, 32'h0);
      ce = 1'b0;
      rst = 1'b0;
      tick();

      // Two full words, big-endian assembly
      start_load();
      send_byte(8'h34, 1'b0);
      check_eq("t2_busy_in_load", {31'b0, busy_b}, 32'h1);
      fetch(32'h0, rb, rs);
      check_eq("t4_inst_nop_in_load", rb, 32'h0);
      check_eq("t4_stall_in_load", {31'b0, stall_b}, 32'h1);
      ce = 1'b0;
      send_byte(8'h02, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0);
      send_word(32'h2021_0002);
      end_load();
      check_eq("t2_busy_after_end", {31'b0, busy_b}, 32'h1);
      tick();
      check_eq("t2_busy_flush", {31'b0, busy_b}, 32'h1);
      tick();
      check_eq("t4_stall_done", {31'b0, stall_b}, 32'h0);
      check_eq("t2_words", {21'b0, words_b}, 32'd2);
      fetch(32'h0, rb, rs);  check_eq("t2_addr0", rb, 32'h3402_0001);
      fetch(32'h4, rb, rs);  check_eq("t2_addr4", rb, 32'h2021_0002);
      fetch(32'h6, rb, rs);  check_eq("t2_addr6", rb, 32'h2021_0002);
      fetch(32'h1000, rb, rs); check_eq("t2_out_of_range", rb, 32'h0);
      ce = 1'b0; #1;
      check_eq("t2_ce0", inst_b, 32'h0);

      // Partial word flushed, load_end with last byte
      start_load();
      send_word(32'hAABB_CCDD);
      send_byte(8'hEE, 1'b1);
      check_eq("t3_busy_flush", {31'b0, busy_b}, 32'h1);
      tick(); tick();
      check_eq("t3_words", {21'b0, words_b}, 32'd2);
      check_eq("t3_busy_idle", {31'b0, busy_b}, 32'h0);
      fetch(32'h0, rb, rs);  check_eq("t3_addr0", rb, 32'hAABB_CCDD);
      fetch(32'h4, rb, rs);  check_eq("t3_addr4", rb, 32'hEE00_0000);
      ce = 1'b0;

      // Overflow on the 4-word instance
      tgt = 1'b1;
      start_load();
      for (int i = 0; i < 4; i++) send_word(32'hA0B0_C0D0 + i);
      check_eq("t5_no_ovf_at_full", {31'b0, ovf_s}, 32'h0);
      send_word(32'h1234_5678);
      check_eq("t5_ovf_set", {31'b0, ovf_s}, 32'h1);
      end_load(); tick(); tick();
      check_eq("t5_ovf_sticky", {31'b0, ovf_s}, 32'h1);
      check_eq("t5_words_sat", {29'b0, words_s}, 32'd4);
      for (int i = 0; i < 4; i++) begin
         fetch(32'(i * 4), rb, rs);
         check_eq($sformatf("t5_mem%0d", i), rs, 32'hA0B0_C0D0 + i);
      end
      fetch(32'h10, rb, rs); check_eq("t5_out_of_range", rs, 32'h0);
      ce = 1'b0;
      start_load();
      check_eq("t5_ovf_cleared", {31'b0, ovf_s}, 32'h0);
      check_eq("t5_words_cleared", {29'b0, words_s}, 32'd0);
      end_load(); tick(); tick();

      // Reset in the middle of a load
      tgt = 1'b0;
      start_load();
      send_word(32'h0102_0304);
      send_byte(8'h05, 1'b0); send_byte(8'h06, 1'b0);
      rst = 1'b1; #1;
      check_eq("t6_busy_immediate", {31'b0, busy_b}, 32'h0);
      check_eq("t6_words_cleared", {21'b0, words_b}, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      fetch(32'h0, rb, rs);  check_eq("t6_addr0_kept", rb, 32'h0102_0304);
      fetch(32'h4, rb, rs);  check_eq("t6_addr4_prior", rb, 32'hEE00_0000);
      check_eq("t6_busy_idle", {31'b0, busy_b}, 32'h0);
      ce = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
